// File: rtl/calc_unit_pkg.sv
// Types, type codes and decode helpers for calc_unit, derived from info.v.
// Optional CALC_STATS_EN build adds an acknowledged-result counter to calc_unit.
`include "info.v"

package calc_unit_pkg;

  localparam int TYPE_W = `INST_TYPE_WIDTH;
  localparam int ROB_W  = `ROB_ID_WIDTH;

  typedef logic [TYPE_W-1:0] inst_type_t;
  typedef logic [ROB_W-1:0]  rob_id_t;

  localparam inst_type_t T_LUI   = `INST_LUI;
  localparam inst_type_t T_AUIPC = `INST_AUIPC;
  localparam inst_type_t T_BEQ   = `INST_BEQ;
  localparam inst_type_t T_ADD   = `INST_ADD;
  localparam inst_type_t T_SUB   = `INST_SUB;
  localparam inst_type_t T_SLL   = `INST_SLL;
  localparam inst_type_t T_SLT   = `INST_SLT;
  localparam inst_type_t T_SLTU  = `INST_SLTU;
  localparam inst_type_t T_XOR   = `INST_XOR;
  localparam inst_type_t T_SRL   = `INST_SRL;
  localparam inst_type_t T_SRA   = `INST_SRA;
  localparam inst_type_t T_OR    = `INST_OR;
  localparam inst_type_t T_AND   = `INST_AND;
  localparam inst_type_t T_ADDI  = `INST_ADDI;
  localparam inst_type_t T_SLTI  = `INST_SLTI;
  localparam inst_type_t T_SLTIU = `INST_SLTIU;
  localparam inst_type_t T_XORI  = `INST_XORI;
  localparam inst_type_t T_ORI   = `INST_ORI;
  localparam inst_type_t T_ANDI  = `INST_ANDI;
  localparam inst_type_t T_SLLI  = `INST_SLLI;
  localparam inst_type_t T_SRLI  = `INST_SRLI;
  localparam inst_type_t T_SRAI  = `INST_SRAI;

  // Operands latched in the E stage.
  typedef struct packed {
    inst_type_t  typ;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    rob_id_t     rob;
  } e_op_t;

  function automatic logic is_calc(input inst_type_t t);
    case (t)
      T_LUI, T_AUIPC, T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL,
      T_SRA, T_OR, T_AND, T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI,
      T_SLLI, T_SRLI, T_SRAI: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic uses_imm(input inst_type_t t);
    case (t)
      T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI,
      T_SLLI, T_SRLI, T_SRAI: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc_unit_alu.sv
// calc_alu: combinational integer result for one calc-type op; zero latency.
// No state and no flow control; is_calc flags whether the type is handled here.
module calc_alu import calc_unit_pkg::*; (
  input  logic [TYPE_W-1:0] typ,
  input  logic [31:0]       v1,
  input  logic [31:0]       v2,
  input  logic [31:0]       imm,
  input  logic [31:0]       pc,
  output logic [31:0]       value,
  output logic              is_calc_o
);

  logic [31:0] op2;
  logic [4:0]  shamt;

  assign op2   = uses_imm(typ) ? imm : v2;
  assign shamt = op2[4:0];

  always_comb begin
    value     = '0;
    is_calc_o = is_calc(typ);
    case (typ)
      T_ADD, T_ADDI:   value = v1 + op2;
      T_SUB:           value = v1 - v2;
      T_AND, T_ANDI:   value = v1 & op2;
      T_OR,  T_ORI:    value = v1 | op2;
      T_XOR, T_XORI:   value = v1 ^ op2;
      T_SLT, T_SLTI:   value = {31'b0, $signed(v1) < $signed(op2)};
      T_SLTU, T_SLTIU: value = {31'b0, v1 < op2};
      T_SLL, T_SLLI:   value = v1 << shamt;
      T_SRL, T_SRLI:   value = v1 >> shamt;
      T_SRA, T_SRAI:   value = $signed(v1) >>> shamt;
      T_LUI:           value = imm;
      T_AUIPC:         value = pc + imm;
      default:         value = '0;
    endcase
  end

endmodule

// File: rtl/info.v
// Shared instruction-type codes and tag widths for the out-of-order core.
// Included once by calc_unit_pkg; every other consumer reads the package.
`ifndef INFO_V
`define INFO_V

`define INST_TYPE_WIDTH 6
`define ROB_ID_WIDTH    4

`define INST_LUI    6'd1
`define INST_AUIPC  6'd2
`define INST_JAL    6'd3
`define INST_JALR   6'd4
`define INST_BEQ    6'd5
`define INST_BNE    6'd6
`define INST_LW     6'd7
`define INST_SW     6'd8
`define INST_ADD    6'd9
`define INST_SUB    6'd10
`define INST_SLL    6'd11
`define INST_SLT    6'd12
`define INST_SLTU   6'd13
`define INST_XOR    6'd14
`define INST_SRL    6'd15
`define INST_SRA    6'd16
`define INST_OR     6'd17
`define INST_AND    6'd18
`define INST_ADDI   6'd19
`define INST_SLTI   6'd20
`define INST_SLTIU  6'd21
`define INST_XORI   6'd22
`define INST_ORI    6'd23
`define INST_ANDI   6'd24
`define INST_SLLI   6'd25
`define INST_SRLI   6'd26
`define INST_SRAI   6'd27

`endif

// File: rtl/calc_unit.sv
// calc_unit: two-stage (E, W) integer unit feeding the CDB; result 2 cycles after accept.
// Backpressure: W holds until out_ack, E fills behind it, then in_ready drops; CALC_STATS_EN adds stat_count.
module calc_unit import calc_unit_pkg::*; (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [31:0]       in_v1,
  input  logic [31:0]       in_v2,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_pc,
  input  logic [ROB_W-1:0]  in_rob,
  output logic              out_valid,
  output logic [31:0]       out_value,
  output logic [ROB_W-1:0]  out_rob,
  input  logic              out_ack,
  output logic              illegal_o
`ifdef CALC_STATS_EN
  ,
  output logic [31:0]       stat_count
`endif
);

  logic        e_vld;
  e_op_t       e_op;
  logic        w_vld;
  logic [31:0] w_val;
  rob_id_t     w_rob;
  logic        illegal_q;
  logic        e_adv;
  logic        accept;
  logic [31:0] alu_val;
  logic        alu_calc;

  assign e_adv    = e_vld && (!w_vld || out_ack);
  assign in_ready = rdy_in && (!e_vld || e_adv);
  assign accept   = in_valid && in_ready;

  // Non-calc ops are dropped at the door so they never occupy E or W.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      e_vld <= 1'b0;
      e_op  <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        e_vld <= 1'b0;
      end else if (accept) begin
        e_vld <= is_calc(in_type);
        e_op  <= '{typ: in_type, v1: in_v1, v2: in_v2, imm: in_imm,
                   pc: in_pc, rob: in_rob};
      end else if (e_adv) begin
        e_vld <= 1'b0;
      end
    end
  end

  calc_alu u_alu (
    .typ       (e_op.typ),
    .v1        (e_op.v1),
    .v2        (e_op.v2),
    .imm       (e_op.imm),
    .pc        (e_op.pc),
    .value     (alu_val),
    .is_calc_o (alu_calc)
  );

  // An ack coinciding with an E advance reloads W rather than emptying it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      w_vld <= 1'b0;
      w_val <= '0;
      w_rob <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        w_vld <= 1'b0;
      end else if (e_adv) begin
        w_vld <= alu_calc;
        w_val <= alu_val;
        w_rob <= e_op.rob;
      end else if (out_ack) begin
        w_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (rdy_in) begin
      illegal_q <= accept && !clear_in && !is_calc(in_type);
    end
  end

  assign out_valid = w_vld;
  assign out_value = w_val;
  assign out_rob   = w_rob;
  assign illegal_o = illegal_q;

`ifdef CALC_STATS_EN
  // Counts results actually taken by the CDB; a flush does not rewind it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= '0;
    end else if (rdy_in && w_vld && out_ack) begin
      stat_count <= stat_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/calc_unit.md
CALC_UNIT -- requirements
Module: calc_unit

Interface
REQ-001 SHALL have ports: clk_in  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: rdy_in  input  1  global enable; low holds all state.
REQ-004 SHALL have ports: clear_in  input  1  synchronous flush (branch mispredict).
REQ-005 SHALL have ports: in_valid  input  1  reservation station offers a calc-type op.
REQ-006 SHALL have ports: in_ready  output  1  unit accepts the op this cycle.
REQ-007 SHALL have ports: in_type  input  `INST_TYPE_WIDTH  instruction type code.
REQ-008 SHALL have ports: in_v1, in_v2, in_imm, in_pc  input  32 each  rs1 value, rs2 value, sign-extended imm, PC.
REQ-009 SHALL have ports: in_rob  input  `ROB_ID_WIDTH  destination ROB tag.
REQ-010 SHALL have ports: out_valid  output  1  result on CDB; out_value  output  32; out_rob  output  `ROB_ID_WIDTH.
REQ-011 SHALL have ports: out_ack  input  1  CDB arbiter grants out_valid this cycle.
REQ-012 SHALL have ports: illegal_o  output  1  one-cycle pulse: accepted op was not calc-type.

Function
REQ-013 SHALL form a two-stage pipeline: E register (latched operands), W register (result, drives outputs).
REQ-014 SHALL accept an op when in_valid && in_ready && rdy_in; in_ready = !E_valid || E_advance.
REQ-015 E_advance SHALL be E_valid && (!W_valid || out_ack).
REQ-016 Latency SHALL be exactly 2 cycles: accepted at edge N, out_valid high from edge N+2 until acknowledged.
REQ-017 Throughput SHALL be 1 op/cycle while out_ack stays high; with out_ack low, W holds value/tag stable and E fills, after which in_ready drops.
REQ-018 W SHALL clear on out_ack unless E advances into it the same edge (simultaneous ack+advance: W reloads).
REQ-019 Results: ADD/ADDI v1+op2; SUB v1-v2; AND/OR/XOR(+I) bitwise; SLT/SLTI signed compare; SLTU/SLTIU unsigned, result 0 or 1; op2 = v2 (R-type) or imm (I-type).
REQ-020 SLL/SRL/SRA(+I) SHALL use only op2[4:0]; SRA arithmetic.
REQ-021 LUI SHALL yield imm; AUIPC SHALL yield pc+imm; all sums modulo 2^32.
REQ-022 An accepted non-calc type SHALL be discarded (never reaches W) and pulse illegal_o the following cycle.
REQ-023 clear_in SHALL invalidate E and W at the edge; an op accepted in the same cycle is discarded; out_valid low the next cycle; clear dominates out_ack.
REQ-024 rdy_in low SHALL freeze E, W and outputs; in_ready SHALL read 0 while rdy_in low; clear_in is ignored while rdy_in low.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear E_valid, W_valid, out_valid, illegal_o; out_value and out_rob to 0.
REQ-026 Reset mid-operation SHALL drop all in-flight ops without CDB output; first acceptance possible on first edge after release.

Configuration
REQ-027 CALC_STATS_EN defined: unit SHALL add output stat_count (32 bits), reset 0, incrementing on each out_valid && out_ack, wrapping at 2^32, unaffected by clear_in.
REQ-028 CALC_STATS_EN undefined: stat_count port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Type codes, `INST_TYPE_WIDTH and `ROB_ID_WIDTH SHALL come from the shared info.v header; no local redefinition.
REQ-030 Result computation SHALL be a combinational sub-module calc_alu (type, v1, v2, imm, pc -> value, is_calc) instantiated once between E and W.

Verification
REQ-031 ADDI v1=0xFFFFFFFF imm=1 tag 3, out_ack=1 -> out_valid 2 cycles later, value 0x00000000, rob 3.
REQ-032 SRA v1=0x80000000 v2=0x00000024 -> 0xF8000000 (shift 4); SLTU v1=1 v2=0xFFFFFFFF -> 1; SLT same -> 0.
REQ-033 Four back-to-back ops, out_ack low 3 cycles -> W holds first result stable, in_ready low after second accept; on ack, results emerge in order, none lost or duplicated.
REQ-034 clear_in in the cycle out_ack and a new accept coincide -> next cycle out_valid=0, E empty, no result for either op.
REQ-035 in_type=branch accepted -> illegal_o pulse 1 cycle later, no out_valid; with CALC_STATS_EN, 5 acked results -> stat_count=5, reset mid-stream -> 0.
